// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory req/gnt/rvalid bus
`timescale 1ns/1ps
interface instr_fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o32;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i32;

    modport master (
        output imem_req_o,
        output imem_addr_o32,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i32
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o32,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i32
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and single-outstanding instruction fetch FSM
// Optional FETCH_PERF_CNT_EN adds retired/stall cycle counters.
`timescale 1ns/1ps
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    instr_fetch_unit_if.master  imem,
    output logic                instr_valid_o,
    output logic [31:0]         instr_o32,
    output logic [5:0]          op_o6,
    output logic [5:0]          funct_o6,
    input  logic                stall_i,
    input  logic                pc_src_i,
    input  logic                jump_i,
    output logic [31:0]         pc_o32,
    output logic [31:0]         pc_plus4_o32
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         retired_cnt_o32,
    output logic [31:0]         stall_cnt_o32
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        req;
    logic        accept;
    logic        retire;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic [31:0] next_pc;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // accept marks the single edge on which rdata is captured; any other rvalid is ignored
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        accept    = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                req = 1'b1;
                if (imem.imem_gnt_i) begin
                    if (imem.imem_rvalid_i) begin
                        accept    = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem.imem_rvalid_i) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall_i) begin
                    retire    = 1'b1;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pc_plus4   = pc + 32'd4;
    assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump_i) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (pc_src_i) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
        end else begin
            if (accept) begin
                instr <= imem.imem_rdata_i32;
            end
            if (retire) begin
                pc <= next_pc;
            end
            instr_valid <= (state_nxt == ISSUE);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            retired_cnt_o32 <= 32'd0;
            stall_cnt_o32   <= 32'd0;
        end else begin
            if (retire) begin
                retired_cnt_o32 <= retired_cnt_o32 + 32'd1;
            end
            if (state == ISSUE && stall_i) begin
                stall_cnt_o32 <= stall_cnt_o32 + 32'd1;
            end
        end
    end
`endif

    assign imem.imem_req_o    = req;
    assign imem.imem_addr_o32 = pc;
    assign instr_valid_o      = instr_valid;
    assign instr_o32          = instr;
    assign op_o6              = instr[31:26];
    assign funct_o6           = instr[5:0];
    assign pc_o32             = pc;
    assign pc_plus4_o32       = pc_plus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized fetch bench with transaction-level PC model
`timescale 1ns/1ps
module tb_instr_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid, stall, pc_src, jump;
    logic [31:0] instr, pc, pc_plus4;
    logic [5:0]  op, funct;
    logic        w_valid;
    logic [31:0] w_instr, w_pc, w_pc_plus4;
    logic [5:0]  w_op, w_funct;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retired_cnt, stall_cnt, w_retired_cnt, w_stall_cnt;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit_if imem ();
    instr_fetch_unit_if imem_w ();

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .imem(imem),
        .instr_valid_o(instr_valid), .instr_o32(instr), .op_o6(op), .funct_o6(funct),
        .stall_i(stall), .pc_src_i(pc_src), .jump_i(jump),
        .pc_o32(pc), .pc_plus4_o32(pc_plus4)
`ifdef FETCH_PERF_CNT_EN
        , .retired_cnt_o32(retired_cnt), .stall_cnt_o32(stall_cnt)
`endif
    );

    // second instance parked at the top of the address space to observe PC wrap
    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk_i(clk), .rst_n_i(rst_n), .imem(imem_w),
        .instr_valid_o(w_valid), .instr_o32(w_instr), .op_o6(w_op), .funct_o6(w_funct),
        .stall_i(1'b0), .pc_src_i(1'b0), .jump_i(1'b0),
        .pc_o32(w_pc), .pc_plus4_o32(w_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
        , .retired_cnt_o32(w_retired_cnt), .stall_cnt_o32(w_stall_cnt)
`endif
    );

    assign imem_w.imem_gnt_i     = 1'b1;
    assign imem_w.imem_rvalid_i  = 1'b1;
    assign imem_w.imem_rdata_i32 = 32'd0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    logic [31:0] exp_stall;
    logic [31:0] mem_ovr [logic [31:0]];
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_base;
`endif

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input logic src, input logic jmp);
        logic [31:0] p4;
        int          off;
        p4 = p + 32'd4;
        if (jmp) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        off = int'($signed(w[15:0])) * 4;
        if (src) return p4 + 32'(off);
        return p4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic check_issue(input logic [31:0] w);
        check("issue_valid", {31'd0, instr_valid}, 32'd1);
        check("issue_req", {31'd0, imem.imem_req_o}, 32'd0);
        check("issue_instr", instr, w);
        check("issue_op", {26'd0, op}, {26'd0, w[31:26]});
        check("issue_funct", {26'd0, funct}, {26'd0, w[5:0]});
        check("issue_pc", pc, exp_pc);
        check("issue_pc_plus4", pc_plus4, exp_pc + 32'd4);
    endtask

    task automatic do_instr(input int gdly, input int rlat, input int nstall,
                            input logic src, input logic jmp);
        logic [31:0] w;
        logic [31:0] nxt;
        int          guard;
        w = mem_word(exp_pc);
        guard = 0;
        while (imem.imem_req_o !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("req_seen", {31'd0, imem.imem_req_o}, 32'd1);
        check("fetch_addr", imem.imem_addr_o32, exp_pc);
        for (int k = 0; k < gdly; k++) begin
            imem.imem_gnt_i     = 1'b0;
            imem.imem_rvalid_i  = 1'($urandom_range(0, 1));
            imem.imem_rdata_i32 = $urandom;
            @(negedge clk);
            check("req_hold", {31'd0, imem.imem_req_o}, 32'd1);
            check("addr_hold", imem.imem_addr_o32, exp_pc);
            check("valid_low", {31'd0, instr_valid}, 32'd0);
        end
        imem.imem_gnt_i     = 1'b1;
        imem.imem_rvalid_i  = (rlat == 0);
        imem.imem_rdata_i32 = (rlat == 0) ? w : $urandom;
        @(negedge clk);
        if (rlat > 0) begin
            imem.imem_gnt_i    = 1'b0;
            imem.imem_rvalid_i = 1'b0;
            check("wait_req_low", {31'd0, imem.imem_req_o}, 32'd0);
            for (int k = 0; k < rlat - 1; k++) begin
                @(negedge clk);
                check("wait_req_low", {31'd0, imem.imem_req_o}, 32'd0);
                check("wait_valid_low", {31'd0, instr_valid}, 32'd0);
            end
            imem.imem_rvalid_i  = 1'b1;
            imem.imem_rdata_i32 = w;
            @(negedge clk);
        end
        imem.imem_gnt_i     = 1'b0;
        imem.imem_rvalid_i  = 1'($urandom_range(0, 1));
        imem.imem_rdata_i32 = $urandom;
        check_issue(w);
        for (int k = 0; k < nstall; k++) begin
            stall  = 1'b1;
            pc_src = 1'($urandom_range(0, 1));
            jump   = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_stall++;
            imem.imem_rvalid_i  = 1'($urandom_range(0, 1));
            imem.imem_rdata_i32 = $urandom;
            check_issue(w);
        end
        stall  = 1'b0;
        pc_src = src;
        jump   = jmp;
        nxt    = model_next(exp_pc, w, src, jmp);
        @(negedge clk);
        exp_pc = nxt;
        exp_ret++;
        imem.imem_rvalid_i = 1'b0;
        check("retire_valid", {31'd0, instr_valid}, 32'd0);
        check("next_req", {31'd0, imem.imem_req_o}, 32'd1);
        check("next_addr", imem.imem_addr_o32, exp_pc);
`ifdef FETCH_PERF_CNT_EN
        check("retired_cnt", retired_cnt, exp_ret);
        check("stall_cnt", stall_cnt, exp_stall);
`endif
        stall  = 1'($urandom_range(0, 1));
        pc_src = 1'($urandom_range(0, 1));
        jump   = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        imem.imem_gnt_i     = 1'b0;
        imem.imem_rvalid_i  = 1'b0;
        imem.imem_rdata_i32 = 32'd0;
        stall  = 1'b0;
        pc_src = 1'b0;
        jump   = 1'b0;
        rst_n  = 1'b0;
        exp_pc    = RST_PC;
        exp_ret   = 32'd0;
        exp_stall = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, imem.imem_req_o}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", pc, 32'h0000_0040);
        check("rst_pc_plus4", pc_plus4, 32'h0000_0044);
`ifdef FETCH_PERF_CNT_EN
        check("rst_retired_cnt", retired_cnt, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("first_req", {31'd0, imem.imem_req_o}, 32'd1);
        check("first_addr", imem.imem_addr_o32, 32'h0000_0040);
        check("wrap_first_addr", imem_w.imem_addr_o32, 32'hFFFF_FFFC);

        do_instr(0, 0, 0, 1'b0, 1'b0);
        check("lit_seq", imem.imem_addr_o32, 32'h0000_0044);
        check("wrap_req", {31'd0, imem_w.imem_req_o}, 32'd1);
        check("wrap_addr", imem_w.imem_addr_o32, 32'h0000_0000);

        mem_ovr[32'h0000_0044] = 32'h0800_0040;
        do_instr(0, 0, 0, 1'b0, 1'b1);
        check("lit_jump", imem.imem_addr_o32, 32'h0000_0100);

        mem_ovr[32'h0000_0100] = 32'h1000_FFFF;
        do_instr(1, 1, 0, 1'b1, 1'b0);
        check("lit_beq_neg", imem.imem_addr_o32, 32'h0000_0100);
        do_instr(0, 0, 0, 1'b0, 1'b0);
        check("lit_beq_fall", imem.imem_addr_o32, 32'h0000_0104);

        mem_ovr[32'h0000_0104] = 32'h0BFF_FFFF;
        do_instr(0, 0, 0, 1'b0, 1'b1);
        check("lit_jump_max", imem.imem_addr_o32, 32'h0FFF_FFFC);
        do_instr(0, 2, 0, 1'b0, 1'b0);
        check("lit_region_cross", imem.imem_addr_o32, 32'h1000_0000);

        mem_ovr[32'h1000_0000] = 32'h0800_0010;
        do_instr(0, 0, 1, 1'b1, 1'b1);
        check("lit_jump_wins", imem.imem_addr_o32, 32'h1000_0040);

`ifdef FETCH_PERF_CNT_EN
        stall_base = stall_cnt;
`endif
        do_instr(3, 2, 4, 1'b0, 1'b0);
        check("lit_slow_mem", imem.imem_addr_o32, 32'h1000_0044);
`ifdef FETCH_PERF_CNT_EN
        check("lit_stall_delta", stall_cnt - stall_base, 32'd4);
`endif

        repeat (150) begin
            do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        imem.imem_gnt_i    = 1'b1;
        imem.imem_rvalid_i = 1'b0;
        @(negedge clk);
        check("rstw_in_wait", {31'd0, imem.imem_req_o}, 32'd0);
        rst_n               = 1'b0;
        imem.imem_gnt_i     = 1'b0;
        imem.imem_rvalid_i  = 1'b1;
        imem.imem_rdata_i32 = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rstw_req", {31'd0, imem.imem_req_o}, 32'd0);
        check("rstw_valid", {31'd0, instr_valid}, 32'd0);
        check("rstw_pc", pc, 32'h0000_0040);
        check("rstw_instr", instr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        imem.imem_rvalid_i = 1'b0;
        check("rstw_refetch_req", {31'd0, imem.imem_req_o}, 32'd1);
        check("rstw_refetch_addr", imem.imem_addr_o32, 32'h0000_0040);
        check("rstw_stray_ignored", {31'd0, instr_valid}, 32'd0);
        exp_pc    = RST_PC;
        exp_ret   = 32'd0;
        exp_stall = 32'd0;
        do_instr(0, 1, 2, 1'b0, 1'b0);
        check("rstw_after", imem.imem_addr_o32, 32'h0000_0044);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
